// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared types and helpers for the data SRAM responder
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;
  localparam int AGE_W      = 4;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [BUS_DATA_W-1:0] word;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  function automatic logic [BUS_DATA_W-1:0] merge_bytes(
    input logic [BUS_DATA_W-1:0] old_word,
    input logic [BUS_DATA_W-1:0] new_word,
    input logic [BUS_STRB_W-1:0] strb
  );
    logic [BUS_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BUS_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dsram_resp_fifo.sv
// rtl/dsram_resp_fifo.sv - in-order response FIFO with per-entry saturating age counters
module dsram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 35,
  parameter int AGE_W = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data,
  output logic [AGE_W-1:0] head_age
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A fresh entry shows age 1 in the cycle after its push; older entries keep ageing.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i)) begin
          valid_q[i] <= 1'b1;
          age_q[i]   <= AGE_W'(1);
        end else if (pop && rd_ptr == PTR_W'(i)) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i] && age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = data_q[rd_ptr];
  assign head_age  = age_q[rd_ptr];

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - SRAM-like data port responder with configurable accept/return latency
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ADDR_DELAY = 0,
  parameter int DATA_DELAY = 1,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [AGE_W-1:0] ADDR_DLY = AGE_W'(ADDR_DELAY);
  localparam logic [AGE_W-1:0] DATA_DLY = AGE_W'(DATA_DELAY);

  logic [BUS_DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [AGE_W-1:0]      wait_cnt;
  logic                  accept;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic [AGE_W-1:0]      head_age;
  logic [RESP_W-1:0]     head_data;
  resp_t                 head;
  resp_t                 push_entry;
  logic                  unused_bits;

  assign idx     = addr[ADDR_WIDTH+1:2];
  assign addr_ok = req && !full && (wait_cnt == ADDR_DLY);
  assign accept  = req && addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!req || addr_ok) begin
      wait_cnt <= '0;
    end else if (wait_cnt < ADDR_DLY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Memory is deliberately left out of reset so stores survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
  end

  always_comb begin
    push_entry      = '0;
    push_entry.wr   = wr;
    push_entry.size = size;
    push_entry.word = wr ? '0 : mem[idx];
  end

  dsram_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESP_W),
    .AGE_W (AGE_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (data_ok),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_data (head_data),
    .head_age  (head_age)
  );

  assign head    = head_data;
  assign data_ok = !empty && (head_age >= DATA_DLY);
  assign rdata   = (data_ok && !head.wr) ? head.word : '0;

  assign unused_bits = ^{head.size, count, addr[31:ADDR_WIDTH+2], addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        req0, req1, req2;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        aok0, aok1, aok2;
  logic        dok0, dok1, dok2;
  logic [31:0] rd0, rd1, rd2;

  int checks = 0;
  int errors = 0;

  data_sram_responder u0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok0), .data_ok(dok0), .rdata(rd0)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .ADDR_DELAY(3)) u1 (
    .clk(clk), .reset(reset), .req(req1), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .DATA_DELAY(4), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok2), .data_ok(dok2), .rdata(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put2(input logic [31:0] a, input logic [31:0] d);
    int n;
    cyc();
    req2 = 1'b1; wr = 1'b1; addr = a; wdata = d; wstrb = 4'hF;
    #1;
    n = 0;
    while (!aok2 && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk("put2_accept", 32'(aok2), 32'd1);
  endtask

  logic [8:0]  u1_aok, u1_dok;
  logic [9:0]  u2_aok, u2_dok;
  logic [31:0] u2_rd [10];
  logic [31:0] ld_addr [3];

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    wr = 1'b0; size = 2'd2; addr = '0; wstrb = '0; wdata = '0;
    u1_aok = 9'b010001000;
    u1_dok = 9'b100010000;
    u2_aok = 10'b0000100011;
    u2_dok = 10'b1000110000;
    for (int i = 0; i < 10; i++) u2_rd[i] = 32'h0;
    u2_rd[4] = 32'hA0A0A0A0;
    u2_rd[5] = 32'hB0B0B0B0;
    u2_rd[9] = 32'hC0C0C0C0;
    ld_addr[0] = 32'h10; ld_addr[1] = 32'h14; ld_addr[2] = 32'h18;

    cyc(); cyc();
    #1;
    chk("rst_aok", 32'(aok0), 32'd0);
    chk("rst_dok", 32'(dok0), 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_aok", 32'(aok0), 32'd0);
      chk("idle_dok", 32'(dok0), 32'd0);
      chk("idle_rdata", rd0, 32'd0);
      cyc();
    end

    // Full-word store then load to the same word.
    req0 = 1'b1; wr = 1'b1; addr = 32'h100; wstrb = 4'hF; wdata = 32'hDEADBEEF;
    #1;
    chk("st_aok", 32'(aok0), 32'd1);
    chk("st_dok_early", 32'(dok0), 32'd0);
    cyc();
    wr = 1'b0;
    #1;
    chk("ld_aok", 32'(aok0), 32'd1);
    chk("st_resp_dok", 32'(dok0), 32'd1);
    chk("st_resp_rdata", rd0, 32'd0);
    cyc();
    req0 = 1'b0;
    #1;
    chk("ld_dok", 32'(dok0), 32'd1);
    chk("ld_rdata", rd0, 32'hDEADBEEF);
    chk("idle_aok2", 32'(aok0), 32'd0);
    cyc();
    #1;
    chk("ld_done", 32'(dok0), 32'd0);

    // Byte-lane store over a full word; lane data is pre-aligned by the requester.
    cyc();
    req0 = 1'b1; wr = 1'b1; addr = 32'h100; wstrb = 4'hF; wdata = 32'h11223344;
    #1;
    chk("pre_aok", 32'(aok0), 32'd1);
    cyc();
    addr = 32'h102; wstrb = 4'b0100; wdata = 32'h00AA0000;
    #1;
    chk("bst_aok", 32'(aok0), 32'd1);
    chk("pre_resp", 32'(dok0), 32'd1);
    cyc();
    wr = 1'b0; addr = 32'h100;
    #1;
    chk("bld_aok", 32'(aok0), 32'd1);
    cyc();
    addr = 32'h0004_0100;
    #1;
    chk("wrap_aok", 32'(aok0), 32'd1);
    chk("bld_dok", 32'(dok0), 32'd1);
    chk("bld_rdata", rd0, 32'h11AA3344);
    cyc();
    req0 = 1'b0;
    #1;
    chk("wrap_dok", 32'(dok0), 32'd1);
    chk("wrap_rdata", rd0, 32'h11AA3344);

    // Address delay of three cycles, restarting for the next request.
    for (int c = 0; c < 9; c++) begin
      cyc();
      req1 = (c <= 7); wr = (c <= 3); addr = 32'h100; wstrb = 4'hF; wdata = 32'h12345678;
      #1;
      chk("adly_aok", 32'(aok1), 32'(u1_aok[c]));
      chk("adly_dok", 32'(dok1), 32'(u1_dok[c]));
      chk("adly_rdata", rd1, (c == 8) ? 32'h12345678 : 32'h0);
    end
    cyc();
    req1 = 1'b0;

    put2(32'h10, 32'hA0A0A0A0);
    put2(32'h14, 32'hB0B0B0B0);
    put2(32'h18, 32'hC0C0C0C0);
    cyc();
    req2 = 1'b0;
    repeat (10) cyc();

    // Three back-to-back loads into a 2-deep queue with data delay 4.
    for (int c = 0; c < 10; c++) begin
      cyc();
      req2 = (c <= 5); wr = 1'b0;
      addr = ld_addr[(c == 0) ? 0 : (c == 1) ? 1 : 2];
      #1;
      chk("q_aok", 32'(aok2), 32'(u2_aok[c]));
      chk("q_dok", 32'(dok2), 32'(u2_dok[c]));
      chk("q_rdata", rd2, u2_rd[c]);
    end
    cyc();
    req2 = 1'b0;
    repeat (4) cyc();

    // Reset with two loads outstanding discards them; memory contents survive.
    req2 = 1'b1; wr = 1'b0; addr = 32'h10;
    #1;
    chk("rr_aok0", 32'(aok2), 32'd1);
    cyc();
    addr = 32'h14;
    #1;
    chk("rr_aok1", 32'(aok2), 32'd1);
    cyc();
    req2 = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_no_dok", 32'(dok2), 32'd0);
      cyc();
    end
    req2 = 1'b1; addr = 32'h10;
    #1;
    chk("rr_reload_aok", 32'(aok2), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      req2 = 1'b0;
      #1;
      chk("rr_reload_dok", 32'(dok2), (i == 4) ? 32'd1 : 32'd0);
      chk("rr_reload_rdata", rd2, (i == 4) ? 32'hA0A0A0A0 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
